// File: rtl/sdr_stream_pkg.sv
// sdr_stream_pkg
// Shared definitions for the IQ frame packer: FSM state encoding, the
// default frame sync pattern, header field positions and header word
// builders.
// Optional feature macro: IQ_PACKER_CHECKSUM_EN adds the TRAIL state.
package sdr_stream_pkg;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h5344_5200;

  // Header word 0: {sync, seq}; header word 1: {drops, length}
  localparam int HDR_SYNC_MSB  = 31;
  localparam int HDR_SYNC_LSB  = 8;
  localparam int HDR_SEQ_MSB   = 7;
  localparam int HDR_SEQ_LSB   = 0;
  localparam int HDR_DROPS_MSB = 31;
  localparam int HDR_DROPS_LSB = 16;
  localparam int HDR_LEN_MSB   = 15;
  localparam int HDR_LEN_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_PAY_I = 3'd3,
    ST_PAY_Q = 3'd4
`ifdef IQ_PACKER_CHECKSUM_EN
    ,
    ST_TRAIL = 3'd5
`endif
  } pack_state_t;

  function automatic logic [31:0] hdr0_word(input logic [23:0] sync_hi,
                                            input logic [7:0]  seq);
    logic [31:0] word;
    word = '0;
    word[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync_hi;
    word[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
    return word;
  endfunction

  function automatic logic [31:0] hdr1_word(input logic [15:0] drops,
                                            input logic [15:0] len);
    logic [31:0] word;
    word = '0;
    word[HDR_DROPS_MSB:HDR_DROPS_LSB] = drops;
    word[HDR_LEN_MSB:HDR_LEN_LSB]     = len;
    return word;
  endfunction

endpackage

// File: rtl/iq_frame_packer_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a first-word-fall-through head. rd_data is the
// current head and rd_next the entry behind it, so the consumer can load
// the next word in the same edge that pops the head.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, wr_data     write strobe (ignored when full) and data
//   pop               read strobe (ignored when empty)
//   rd_data, rd_next  head entry and the entry after it
//   full, empty       status
//   count             number of stored entries
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_next,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign rd_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iq_frame_packer.sv
// iq_frame_packer
// Buffers DDC I/Q pairs in a FIFO and emits framed 32-bit stream words:
//   HDR0 {sync[31:8], seq}, HDR1 {drop_count, FRAME_SAMPLES},
//   then I,Q per sample, optionally a TRAIL XOR checksum word.
// A frame starts only once a whole frame is buffered, so it is gapless.
// Optional feature macro: IQ_PACKER_CHECKSUM_EN (appends TRAIL word).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   enable                         accept new DDC samples
//   i_component, q_component       DDC sample
//   ddc_valid                      sample strobe, no backpressure
//   clear_ovf                      clears sticky overflow
//   out_data/out_valid/out_last    stream output, out_ready accept
//   overflow, drop_count           sticky overflow, saturating drop count
//
// state    | meaning
// IDLE     | waiting for FRAME_SAMPLES buffered pairs
// HDR0     | presenting sync/seq header word
// HDR1     | presenting drop count/length header word
// PAY_I    | presenting I word of FIFO head
// PAY_Q    | presenting Q word of FIFO head, pops on accept
// TRAIL    | presenting XOR checksum (checksum build only)
module iq_frame_packer
  import sdr_stream_pkg::*;
#(
  parameter int          FRAME_SAMPLES = 64,
  parameter int          FIFO_DEPTH    = 256,
  parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] i_component,
  input  logic [31:0] q_component,
  input  logic        ddc_valid,
  input  logic        clear_ovf,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  FRAME_CNT = CW'(FRAME_SAMPLES);
  localparam logic [15:0]    FRAME_LEN = 16'(FRAME_SAMPLES);
  localparam logic [15:0]    LAST_IDX  = 16'(FRAME_SAMPLES - 1);

  pack_state_t   state;
  logic [63:0]   head;
  logic [63:0]   head_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          wr_attempt;
  logic          fifo_push;
  logic          fifo_pop;
  logic          drop;
  logic          accept;
  logic          last_sample;
  logic [7:0]    seq;
  logic [15:0]   sample_idx;
  logic [15:0]   drops_snap;
  logic [31:0]   q_hold;

  assign wr_attempt  = ddc_valid & enable;
  // Full is judged on the pre-edge count: a same-cycle pop does not save it.
  assign fifo_push   = wr_attempt & ~fifo_full;
  assign drop        = wr_attempt & fifo_full;
  assign accept      = out_valid & out_ready;
  assign fifo_pop    = accept && (state == ST_PAY_Q);
  assign last_sample = (sample_idx == LAST_IDX);

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({i_component, q_component}),
    .pop     (fifo_pop),
    .rd_data (head),
    .rd_next (head_next),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

`ifdef IQ_PACKER_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (state == ST_IDLE) begin
      csum <= '0;
    end else if (accept && (state != ST_TRAIL)) begin
      csum <= csum ^ out_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      seq        <= '0;
      sample_idx <= '0;
      drops_snap <= '0;
      q_hold     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fifo_count >= FRAME_CNT) begin
            state      <= ST_HDR0;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            out_data   <= hdr0_word(SYNC_WORD[31:8], seq);
            drops_snap <= drop_count;
            sample_idx <= '0;
          end
        end
        ST_HDR0: begin
          if (accept) begin
            state    <= ST_HDR1;
            out_data <= hdr1_word(drops_snap, FRAME_LEN);
          end
        end
        ST_HDR1: begin
          if (accept) begin
            state    <= ST_PAY_I;
            out_data <= head[63:32];
            q_hold   <= head[31:0];
          end
        end
        ST_PAY_I: begin
          if (accept) begin
            state    <= ST_PAY_Q;
            out_data <= q_hold;
`ifdef IQ_PACKER_CHECKSUM_EN
            out_last <= 1'b0;
`else
            out_last <= last_sample;
`endif
          end
        end
        ST_PAY_Q: begin
          if (accept) begin
            if (last_sample) begin
`ifdef IQ_PACKER_CHECKSUM_EN
              state    <= ST_TRAIL;
              out_data <= csum ^ out_data;
              out_last <= 1'b1;
`else
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              seq       <= seq + 8'd1;
`endif
            end else begin
              // Head is popped on this edge, so the next pair comes from rd_next.
              state      <= ST_PAY_I;
              sample_idx <= sample_idx + 16'd1;
              out_data   <= head_next[63:32];
              q_hold     <= head_next[31:0];
            end
          end
        end
`ifdef IQ_PACKER_CHECKSUM_EN
        ST_TRAIL: begin
          if (accept) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            seq       <= seq + 8'd1;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
module tb_iq_frame_packer;

`ifdef IQ_PACKER_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] i_component;
  logic [31:0] q_component;
  logic        ddc_valid;
  logic        clear_ovf;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        overflow;
  logic [15:0] drop_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  iq_frame_packer #(
    .FRAME_SAMPLES (4),
    .FIFO_DEPTH    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .i_component (i_component),
    .q_component (q_component),
    .ddc_valid   (ddc_valid),
    .clear_ovf   (clear_ovf),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepted-word capture and stall stability, sampled on the falling edge.
  logic [31:0] wq[$];
  bit          lq[$];
  int          cq[$];
  int          cyc = 0;
  bit          stall_pend = 0;
  logic [31:0] stall_data;
  logic        stall_last;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, stall_data);
        chk("stall_last", 32'(out_last), 32'(stall_last));
      end
      if (out_valid && out_ready) begin
        wq.push_back(out_data);
        lq.push_back(out_last);
        cq.push_back(cyc);
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] i0, input logic [31:0] q0);
    tick();
    for (int k = 0; k < n; k++) begin
      ddc_valid   = 1'b1;
      i_component = i0 + 32'(k);
      q_component = q0 + 32'(k);
      tick();
    end
    ddc_valid = 1'b0;
  endtask

  task automatic get_word(output logic [31:0] w, output bit l, output int c);
    int n = 0;
    while (wq.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("word_available", 32'(wq.size() > 0), 32'd1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      l = lq.pop_front();
      c = cq.pop_front();
    end else begin
      w = '0;
      l = 0;
      c = 0;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] seq, input logic [15:0] drops,
                             input logic [31:0] i0, input logic [31:0] q0, input bit nobub);
    logic [31:0] e[11];
    logic [31:0] w;
    bit          l;
    int          c;
    int          pc;
    e[0] = 32'h5344_5200 | {24'd0, seq};
    e[1] = {drops, 16'd4};
    for (int k = 0; k < 4; k++) begin
      e[2 + 2*k] = i0 + 32'(k);
      e[3 + 2*k] = q0 + 32'(k);
    end
    e[10] = '0;
    for (int k = 0; k < 10; k++) e[10] = e[10] ^ e[k];
    pc = 0;
    for (int j = 0; j < FLEN; j++) begin
      get_word(w, l, c);
      chk($sformatf("%s_word%0d", tag, j), w, e[j]);
      chk($sformatf("%s_last%0d", tag, j), 32'(l), 32'(j == FLEN - 1));
      if (nobub && j > 0) chk($sformatf("%s_gap%0d", tag, j), 32'(c - pc), 32'd1);
      pc = c;
    end
  endtask

  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int lasts;
  int n;

  initial begin
    rst = 1'b1; enable = 1'b1; ddc_valid = 1'b0; clear_ovf = 1'b0;
    i_component = '0; q_component = '0; out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Basic frame, latency and no-bubble streaming
    push_n(4, 32'h11, 32'h21);
    @(negedge clk);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'd1);
    check_frame("f0", 8'h00, 16'd0, 32'h11, 32'h21, 1);
    push_n(4, 32'h51, 32'h61);
    check_frame("f1", 8'h01, 16'd0, 32'h51, 32'h61, 1);

    // Backpressure pattern 1,0,0,1 across a frame
    out_ready = 1'b0;
    push_n(4, 32'h31, 32'h41);
    for (int k = 0; k < 120 && wq.size() < FLEN; k++) begin
      out_ready = pat[k % 4];
      tick();
    end
    out_ready = 1'b1;
    check_frame("bp", 8'h02, 16'd0, 32'h31, 32'h41, 0);
    repeat (6) tick();
    chk("bp_no_extra", 32'(wq.size()), 32'd0);

    // Overflow: depth 8, 10 pushes while stalled
    out_ready = 1'b0;
    push_n(10, 32'h71, 32'h81);
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd2);
    tick();
    out_ready = 1'b1;
    check_frame("ovf_a", 8'h03, 16'd0, 32'h71, 32'h81, 1);
    check_frame("ovf_b", 8'h04, 16'd2, 32'h75, 32'h85, 1);
    tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    @(negedge clk);
    chk("clr_ovf_flag", 32'(overflow), 32'd0);
    chk("clr_ovf_drops", 32'(drop_count), 32'd2);

    // enable=0 samples are discarded without counting
    tick();
    enable = 1'b0;
    push_n(3, 32'h91, 32'h99);
    repeat (3) tick();
    @(negedge clk);
    chk("dis_drops", 32'(drop_count), 32'd2);
    chk("dis_valid", 32'(out_valid), 32'd0);
    tick();
    enable = 1'b1;
    push_n(4, 32'hA1, 32'hB1);
    check_frame("en", 8'h05, 16'd2, 32'hA1, 32'hB1, 1);

    // Reset during PAY_Q of sample 2
    push_n(4, 32'hC1, 32'hD1);
    n = 0;
    while (!(out_valid && out_data === 32'hD3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_point_found", 32'(n < 50), 32'd1);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_drops", 32'(drop_count), 32'd0);
    lasts = 0;
    foreach (lq[k]) lasts += int'(lq[k]);
    chk("midrst_no_last", 32'(lasts), 32'd0);
    wq.delete(); lq.delete(); cq.delete();

    // 257 frames: seq runs 0x00..0xFF then wraps to 0x00
    for (int f = 0; f < 257; f++) begin
      push_n(4, 32'h1000 + 32'(4*f), 32'h8000 + 32'(4*f));
      check_frame($sformatf("seq%0d", f), 8'(f), 16'd0,
                  32'h1000 + 32'(4*f), 32'h8000 + 32'(4*f), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
